// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
//
// Shared VGA timing definitions. The default 640x480@60 constants live here so
// that the timing generator and the pixel generator agree on one raster
// geometry. Also holds the count types, the sync sideband bundle and its idle
// value, and a small window-decode helper.
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

  // Default 640x480@60 (25 MHz pixel clock) horizontal timing, in pixels.
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  // Default vertical timing, in lines.
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Counter widths shared with the consumers of hcount/vcount.
  localparam int COUNT_W = 10;
  localparam int FRAME_W = 8;

  typedef logic [COUNT_W-1:0] count_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Sideband that travels through the alignment delay line.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } sync_bits_t;

  // Idle (reset) value of the sideband: syncs inactive, video blanked.
  localparam sync_bits_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_window(count_t pos, count_t lo, count_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Raster-timing bundle between the timing generator (master) and its
// consumers: pixel generator, ROM address logic, game FSM and the video DAC
// (slave).
//
//   hcount, vcount  undelayed pixel/line counts
//   visible         undelayed active-area flag
//   line_start      pulse at hcount==0
//   frame_start     pulse at hcount==0 && vcount==0
//   frame_count     frames completed since reset (wraps)
//   vga_hs, vga_vs  active-low syncs, aligned to pixel data
//   vga_blank_n     active-low blank, aligned to pixel data
//   vga_sync_n      DAC composite sync (unused, held low)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  count_t hcount;
  count_t vcount;
  logic   visible;
  logic   line_start;
  logic   frame_start;
  frame_t frame_count;
  logic   vga_hs;
  logic   vga_vs;
  logic   vga_blank_n;
  logic   vga_sync_n;

  modport master (
    output hcount, vcount, visible, line_start, frame_start, frame_count,
           vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );

  modport slave (
    input  hcount, vcount, visible, line_start, frame_start, frame_count,
           vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_sync_delay_line
//
// Parameterised shift register used to align sideband bits (sync, blank and
// any future overlay flags) with pixel data that arrives a fixed number of
// clocks after the raster count.
//
//   clk   clock
//   rst   asynchronous active-high reset; every stage loads RESET_VAL
//   din   WIDTH-bit sideband input
//   dout  din delayed by exactly DEPTH cycles (DEPTH==0 is a wire)
// -----------------------------------------------------------------------------
module vga_timing_gen_sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No stages: clock and reset are intentionally unused.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst;
      assign dout        = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Stage 0 captures din; stage k captures stage k-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= RESET_VAL;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster timing source. Free-running horizontal/vertical counters drive
// the pixel generator directly; the sync and blank strobes for the DAC are
// pushed through a PIX_DELAY-deep delay line so they line up with pixel data
// that is valid one ROM read after the count. Line/frame strobes and a frame
// counter let the game logic update state only between frames.
//
//   vga_clk  pixel clock (25 MHz at default timing)
//   reset    asynchronous active-high reset
//   vga      vga_timing_gen_if master: hcount, vcount, visible, line_start,
//            frame_start, frame_count, vga_hs, vga_vs, vga_blank_n, vga_sync_n
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIX_DELAY = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Reject geometries the 10-bit counters cannot hold and delays the
  // alignment pipeline is not meant for.
  generate
    if (PIX_DELAY < 0 || PIX_DELAY > 4) begin : g_bad_delay
      $error("vga_timing_gen: PIX_DELAY=%0d outside 0..4", PIX_DELAY);
    end
    if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL=%0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL=%0d exceeds 1024", V_TOTAL);
    end
  endgenerate

  // Decode constants at counter width.
  localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
  localparam count_t H_VIS    = count_t'(H_VISIBLE);
  localparam count_t V_VIS    = count_t'(V_VISIBLE);
  localparam count_t HS_START = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t HS_END   = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam count_t VS_START = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t VS_END   = count_t'(V_VISIBLE + V_FRONT + V_SYNC);

  count_t     hcount;
  count_t     vcount;
  frame_t     frame_count;
  logic       h_wrap;
  logic       v_wrap;
  logic       visible;
  sync_bits_t sync_raw;
  sync_bits_t sync_dly;

  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);

  // ---- Raster counters ------------------------------------------------------
  // vcount only moves on a line wrap; frame_count only on the combined
  // line+frame wrap, i.e. the edge that brings both counts back to 0/0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else if (h_wrap) begin
      hcount <= '0;
      if (v_wrap) begin
        vcount      <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        vcount <= vcount + 10'd1;
      end
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // ---- Raw decode (same cycle as the counts) --------------------------------
  assign visible          = (hcount < H_VIS) && (vcount < V_VIS);
  assign sync_raw.hs_n    = ~in_window(hcount, HS_START, HS_END);
  assign sync_raw.vs_n    = ~in_window(vcount, VS_START, VS_END);
  assign sync_raw.blank_n = visible;

  // ---- Alignment delay: sync/blank follow the counts by PIX_DELAY cycles ----
  // Stages reset to the idle pattern so no sync glitch appears after reset.
  vga_timing_gen_sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (PIX_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk  (vga_clk),
    .rst  (reset),
    .din  (sync_raw),
    .dout (sync_dly)
  );

  // ---- Interface outputs ----------------------------------------------------
  assign vga.hcount      = hcount;
  assign vga.vcount      = vcount;
  assign vga.visible     = visible;
  assign vga.line_start  = (hcount == '0);
  assign vga.frame_start = (hcount == '0) && (vcount == '0);
  assign vga.frame_count = frame_count;
  assign vga.vga_hs      = sync_dly.hs_n;
  assign vga.vga_vs      = sync_dly.vs_n;
  assign vga.vga_blank_n = sync_dly.blank_n;
  assign vga.vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Runs five generators side by side from one clock and reset: four with a
// tiny raster (14 x 10) at PIX_DELAY 0, 1, 2, 4 so hundreds of frames fit in
// a short run, and one at default 640x480 timing with PIX_DELAY 1. Every
// output of every instance is compared each cycle against a reference model
// that derives the raster purely from the number of clocks since reset
// (division/modulo), with random asynchronous resets sprinkled in.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int NI = 5;

  // Tiny raster for the fast instances.
  localparam int S_HV = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 14
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 10

  typedef struct {
    int h_vis, h_fp, h_sw, h_bp;
    int v_vis, v_fp, v_sw, v_bp;
    int dly;
  } cfg_t;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       vis;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
  } obs_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   tick    = 0;
  logic chk_en  = 1'b0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if if0 ();
  vga_timing_gen_if if1 ();
  vga_timing_gen_if if2 ();
  vga_timing_gen_if if3 ();
  vga_timing_gen_if if4 ();

  vga_timing_gen #(.H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                   .PIX_DELAY(0)) u0 (.vga_clk(vga_clk), .reset(reset), .vga(if0));
  vga_timing_gen #(.H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                   .PIX_DELAY(1)) u1 (.vga_clk(vga_clk), .reset(reset), .vga(if1));
  vga_timing_gen #(.H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                   .PIX_DELAY(2)) u2 (.vga_clk(vga_clk), .reset(reset), .vga(if2));
  vga_timing_gen #(.H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                   .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                   .PIX_DELAY(4)) u3 (.vga_clk(vga_clk), .reset(reset), .vga(if3));
  vga_timing_gen #(.PIX_DELAY(1)) u4 (.vga_clk(vga_clk), .reset(reset), .vga(if4));

  obs_t obs [NI];
  assign obs[0] = {if0.hcount, if0.vcount, if0.visible, if0.line_start, if0.frame_start,
                   if0.frame_count, if0.vga_hs, if0.vga_vs, if0.vga_blank_n, if0.vga_sync_n};
  assign obs[1] = {if1.hcount, if1.vcount, if1.visible, if1.line_start, if1.frame_start,
                   if1.frame_count, if1.vga_hs, if1.vga_vs, if1.vga_blank_n, if1.vga_sync_n};
  assign obs[2] = {if2.hcount, if2.vcount, if2.visible, if2.line_start, if2.frame_start,
                   if2.frame_count, if2.vga_hs, if2.vga_vs, if2.vga_blank_n, if2.vga_sync_n};
  assign obs[3] = {if3.hcount, if3.vcount, if3.visible, if3.line_start, if3.frame_start,
                   if3.frame_count, if3.vga_hs, if3.vga_vs, if3.vga_blank_n, if3.vga_sync_n};
  assign obs[4] = {if4.hcount, if4.vcount, if4.visible, if4.line_start, if4.frame_start,
                   if4.frame_count, if4.vga_hs, if4.vga_vs, if4.vga_blank_n, if4.vga_sync_n};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cfg_t cfg_of(int i);
    cfg_t c;
    c = '{h_vis: S_HV, h_fp: S_HF, h_sw: S_HS, h_bp: S_HB,
          v_vis: S_VV, v_fp: S_VF, v_sw: S_VS, v_bp: S_VB, dly: 0};
    case (i)
      1: c.dly = 1;
      2: c.dly = 2;
      3: c.dly = 4;
      4: c = '{h_vis: 640, h_fp: 16, h_sw: 96, h_bp: 48,
               v_vis: 480, v_fp: 10, v_sw: 2, v_bp: 33, dly: 1};
      default: ;
    endcase
    return c;
  endfunction

  // Reference: everything follows from t = clocks since reset release.
  // Sync/blank at t are the raw decode at t-dly, idle before that exists.
  function automatic obs_t model(cfg_t c, int t);
    obs_t e;
    int ht = c.h_vis + c.h_fp + c.h_sw + c.h_bp;
    int vt = c.v_vis + c.v_fp + c.v_sw + c.v_bp;
    int h  = t % ht;
    int v  = (t / ht) % vt;
    int hd, vd;
    e.hc  = 10'(h);
    e.vc  = 10'(v);
    e.vis = (h < c.h_vis) && (v < c.v_vis);
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    e.fc  = 8'((t / (ht * vt)) % 256);
    e.sn  = 1'b0;
    if (t < c.dly) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bn = 1'b0;
    end else begin
      hd   = (t - c.dly) % ht;
      vd   = ((t - c.dly) / ht) % vt;
      e.hs = !((hd >= c.h_vis + c.h_fp) && (hd < c.h_vis + c.h_fp + c.h_sw));
      e.vs = !((vd >= c.v_vis + c.v_fp) && (vd < c.v_vis + c.v_fp + c.v_sw));
      e.bn = (hd < c.h_vis) && (vd < c.v_vis);
    end
    return e;
  endfunction

  // Clock count since the last reset release.
  always @(posedge vga_clk or posedge reset) begin
    if (reset) tick <= 0;
    else       tick <= tick + 1;
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    obs_t e;
    forever begin
      @(negedge vga_clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          e = model(cfg_of(i), tick);
          chk($sformatf("u%0d.hcount", i),      64'(obs[i].hc),  64'(e.hc));
          chk($sformatf("u%0d.vcount", i),      64'(obs[i].vc),  64'(e.vc));
          chk($sformatf("u%0d.visible", i),     64'(obs[i].vis), 64'(e.vis));
          chk($sformatf("u%0d.line_start", i),  64'(obs[i].ls),  64'(e.ls));
          chk($sformatf("u%0d.frame_start", i), 64'(obs[i].fs),  64'(e.fs));
          chk($sformatf("u%0d.frame_count", i), 64'(obs[i].fc),  64'(e.fc));
          chk($sformatf("u%0d.vga_hs", i),      64'(obs[i].hs),  64'(e.hs));
          chk($sformatf("u%0d.vga_vs", i),      64'(obs[i].vs),  64'(e.vs));
          chk($sformatf("u%0d.vga_blank_n", i), 64'(obs[i].bn),  64'(e.bn));
          chk($sformatf("u%0d.vga_sync_n", i),  64'(obs[i].sn),  64'(e.sn));
        end
      end
    end
  end

  // Pulse-width / period measurements straight from the timing rules.
  initial begin
    int hs_run = 0, bn_run = 0, vs_run = 0, fs_cnt = 0, fc_prev = 0;
    logic fs_seen = 1'b0;
    forever begin
      @(negedge vga_clk);
      if (!chk_en) continue;
      if (reset) begin
        hs_run = 0; bn_run = 0; vs_run = 0; fs_cnt = 0; fs_seen = 1'b0;
      end else begin
        // Default-timing instance: hsync 96 low, 640 visible pixels per line.
        if (!if4.vga_hs) hs_run++;
        else if (hs_run != 0) begin chk("u4.hs_low_len", 64'(hs_run), 64'd96); hs_run = 0; end
        if (if4.vga_blank_n) bn_run++;
        else if (bn_run != 0) begin chk("u4.blank_hi_len", 64'(bn_run), 64'd640); bn_run = 0; end
        // Tiny-raster instance: vsync spans V_SYNC lines, one frame_start per frame.
        if (!if1.vga_vs) vs_run++;
        else if (vs_run != 0) begin chk("u1.vs_low_len", 64'(vs_run), 64'(S_VS * S_HT)); vs_run = 0; end
        fs_cnt++;
        if (if1.frame_start) begin
          if (fs_seen) begin
            chk("u1.frame_period", 64'(fs_cnt), 64'(S_HT * S_VT));
            chk("u1.frame_count_step", 64'(if1.frame_count), 64'((fc_prev + 1) % 256));
          end
          fs_seen = 1'b1;
          fs_cnt  = 0;
          fc_prev = int'(if1.frame_count);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    @(posedge vga_clk);
    chk_en = 1'b1;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk); #1;
    chk("rst.u4.hcount",      64'(if4.hcount), 64'd0);
    chk("rst.u4.vcount",      64'(if4.vcount), 64'd0);
    chk("rst.u4.vga_hs",      64'(if4.vga_hs), 64'd1);
    chk("rst.u4.vga_vs",      64'(if4.vga_vs), 64'd1);
    chk("rst.u4.vga_blank_n", 64'(if4.vga_blank_n), 64'd0);
    chk("rst.u3.vga_blank_n", 64'(if3.vga_blank_n), 64'd0);
    chk("rst.u1.frame_start", 64'(if1.frame_start), 64'd1);
    chk("rst.u1.line_start",  64'(if1.line_start), 64'd1);
    chk("rst.u1.frame_count", 64'(if1.frame_count), 64'd0);
    reset = 1'b0;
    @(posedge vga_clk); #1;
    chk("rel.u4.hcount", 64'(if4.hcount), 64'd1);
    chk("rel.u1.hcount", 64'(if1.hcount), 64'd1);

    // Long uninterrupted run: frame_count on the tiny raster wraps past 255.
    repeat (257 * S_HT * S_VT + 60) @(negedge vga_clk);
    chk("wrap.u1.frame_count", 64'(if1.frame_count), 64'(((tick / (S_HT * S_VT)) % 256)));

    // Random mid-frame asynchronous resets.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(30, 400)) @(negedge vga_clk);
      @(posedge vga_clk); #2;
      reset = 1'b1;
      #1;
      chk("mid.u4.hcount",      64'(if4.hcount), 64'd0);
      chk("mid.u4.vcount",      64'(if4.vcount), 64'd0);
      chk("mid.u2.hcount",      64'(if2.hcount), 64'd0);
      chk("mid.u2.vcount",      64'(if2.vcount), 64'd0);
      chk("mid.u2.vga_blank_n", 64'(if2.vga_blank_n), 64'd0);
      chk("mid.u3.vga_hs",      64'(if3.vga_hs), 64'd1);
      repeat ($urandom_range(1, 3)) @(posedge vga_clk);
      @(negedge vga_clk); #2;
      reset = 1'b0;
    end

    // Settle for more than two tiny frames after the last reset.
    repeat (3 * S_HT * S_VT) @(negedge vga_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
